// File: rtl/sdspi_arb_pkg.sv
// Shared types and widths for the sdspihost session arbiter.
package sdspi_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_INIT_RST,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_GRANTED,
        ST_DRAIN,
        ST_REINIT
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request after last_owner, wrapping.
module rr_arbiter
    import sdspi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0]   pick_idx
);

    // Scan from last_owner+1 around the ring; the loop is bounded by the widest legal configuration.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        found    = 1'b0;
        cand     = '0;
        pick_oh  = '0;
        pick_idx = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= NUM_REQ) begin
                cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
                if (!found && req[cand]) begin
                    found         = 1'b1;
                    pick_oh[cand] = 1'b1;
                    pick_idx      = cand;
                end
            end
        end
    end

endmodule

// File: rtl/sdspi_host_arbiter.sv
// Shares one sdspihost between NUM_REQ requesters: runs the host reset/init sequence,
// grants whole sessions round-robin and muxes the owner's command interface to the host.
module sdspi_host_arbiter
    import sdspi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int RST_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_reinit,
    input  logic [NUM_REQ-1:0]        req_r_block,
    input  logic [NUM_REQ-1:0]        req_r_multi_block,
    input  logic [NUM_REQ-1:0]        req_r_byte,
    input  logic [NUM_REQ-1:0]        req_w_block,
    input  logic [NUM_REQ-1:0]        req_w_byte,
    input  logic [ADDR_W*NUM_REQ-1:0] req_block_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data_in,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic                      spi_rst,
    output logic                      spi_r_block,
    output logic                      spi_r_multi_block,
    output logic                      spi_r_byte,
    output logic                      spi_w_block,
    output logic                      spi_w_byte,
    output logic [ADDR_W-1:0]         spi_block_addr,
    output logic [DATA_W-1:0]         spi_data_in,
    input  logic                      spi_busy,
    input  logic                      spi_err,
    input  logic [DATA_W-1:0]         spi_data_out,
    output logic                      err_out,
    output logic [DATA_W-1:0]         data_out,
    output logic                      init_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] rst_cnt;
    logic [IDX_W-1:0] owner_idx;
    logic [IDX_W-1:0] last_owner;
    logic             reinit_pend;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_live;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .last_owner (last_owner),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx)
    );

    // Session FSM: host reset/init, grant, drain and owner-requested reinit; all control outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT_RST;
            rst_cnt     <= '0;
            spi_rst     <= 1'b1;
            gnt         <= '0;
            init_done   <= 1'b0;
            owner_idx   <= '0;
            last_owner  <= IDX_W'(NUM_REQ - 1);
            reinit_pend <= 1'b0;
        end else begin
            case (state)
                ST_INIT_RST, ST_REINIT: begin
                    if (rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        spi_rst     <= 1'b0;
                        rst_cnt     <= '0;
                        reinit_pend <= (state == ST_REINIT);
                        state       <= ST_INIT_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_INIT_WAIT: begin
                    if (!spi_busy) begin
                        init_done   <= 1'b1;
                        reinit_pend <= 1'b0;
                        // A reinit keeps the session: the owner and its gnt were never released.
                        state       <= reinit_pend ? ST_GRANTED : ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (|req) begin
                        gnt        <= pick_oh;
                        owner_idx  <= pick_idx;
                        last_owner <= pick_idx;
                        state      <= ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    if (!req[owner_idx]) begin
                        gnt   <= '0;
                        state <= spi_busy ? ST_DRAIN : ST_IDLE;
                    end else if (req_reinit[owner_idx] && !spi_busy) begin
                        spi_rst <= 1'b1;
                        rst_cnt <= '0;
                        state   <= ST_REINIT;
                    end
                end
                ST_DRAIN: begin
                    if (!spi_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT_RST;
            endcase
        end
    end

    // Owner mux: strobes only while the owner still holds req, addr/data whenever an owner exists.
    always_comb begin
        owner_live        = (state == ST_GRANTED) && req[owner_idx];
        spi_r_block       = owner_live && req_r_block[owner_idx];
        spi_r_multi_block = owner_live && req_r_multi_block[owner_idx];
        spi_r_byte        = owner_live && req_r_byte[owner_idx];
        spi_w_block       = owner_live && req_w_block[owner_idx];
        spi_w_byte        = owner_live && req_w_byte[owner_idx];
        spi_block_addr    = '0;
        spi_data_in       = '0;
        if (|gnt) begin
            spi_block_addr = req_block_addr[ADDR_W*int'(owner_idx) +: ADDR_W];
            spi_data_in    = req_data_in[DATA_W*int'(owner_idx) +: DATA_W];
        end
        // Everyone but a granted owner sees the host as busy and holds off commands.
        req_busy = '1;
        if (state == ST_GRANTED) begin
            req_busy[owner_idx] = spi_busy;
        end
    end

    assign err_out  = spi_err;
    assign data_out = spi_data_out;

endmodule

// File: tb/tb_sdspi_host_arbiter.sv
// Directed bench for sdspi_host_arbiter (NUM_REQ=2, RST_CYCLES=4).
module tb_sdspi_host_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req_reinit, req_r_block, req_r_multi_block, req_r_byte, req_w_block, req_w_byte;
    logic [63:0] req_block_addr;
    logic [15:0] req_data_in;
    logic [1:0]  gnt, req_busy;
    logic        spi_rst, spi_r_block, spi_r_multi_block, spi_r_byte, spi_w_block, spi_w_byte;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_in;
    logic        spi_busy, spi_err;
    logic [7:0]  spi_data_out;
    logic        err_out;
    logic [7:0]  data_out;
    logic        init_done;

    int n_cmp = 0;
    int n_err = 0;

    sdspi_host_arbiter #(
        .NUM_REQ    (2),
        .RST_CYCLES (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .req_reinit        (req_reinit),
        .req_r_block       (req_r_block),
        .req_r_multi_block (req_r_multi_block),
        .req_r_byte        (req_r_byte),
        .req_w_block       (req_w_block),
        .req_w_byte        (req_w_byte),
        .req_block_addr    (req_block_addr),
        .req_data_in       (req_data_in),
        .gnt               (gnt),
        .req_busy          (req_busy),
        .spi_rst           (spi_rst),
        .spi_r_block       (spi_r_block),
        .spi_r_multi_block (spi_r_multi_block),
        .spi_r_byte        (spi_r_byte),
        .spi_w_block       (spi_w_block),
        .spi_w_byte        (spi_w_byte),
        .spi_block_addr    (spi_block_addr),
        .spi_data_in       (spi_data_in),
        .spi_busy          (spi_busy),
        .spi_err           (spi_err),
        .spi_data_out      (spi_data_out),
        .err_out           (err_out),
        .data_out          (data_out),
        .init_done         (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_spi_rst"}, spi_rst, 1'b1);
        check({tag, "_gnt"}, gnt, 2'b00);
        check({tag, "_init_done"}, init_done, 1'b0);
        check({tag, "_strobes"}, {spi_r_block, spi_r_multi_block, spi_r_byte, spi_w_block, spi_w_byte}, 5'b0);
        check({tag, "_addr"}, spi_block_addr, 32'h0);
        check({tag, "_data"}, spi_data_in, 8'h0);
        check({tag, "_req_busy"}, req_busy, 2'b11);
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_reinit = '0; req_r_block = '0; req_r_multi_block = '0; req_r_byte = '0;
        req_w_block = '0; req_w_byte = '0; req_block_addr = '0; req_data_in = '0;
        spi_busy = 1'b1; spi_err = 1'b0; spi_data_out = '0;

        // T1: reset values, spi_rst for exactly 4 cycles, init completes when busy falls
        tick(); tick();
        check_reset_vals("t1_reset");
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t1_spi_rst_c%0d", i), spi_rst, (i < 4) ? 1'b1 : 1'b0);
        end
        repeat (6) tick();
        check("t1_init_pending", init_done, 1'b0);
        spi_busy = 1'b0;
        tick();
        check("t1_init_done", init_done, 1'b1);
        check("t1_gnt_idle", gnt, 2'b00);

        // T2: single request granted one cycle later, strobe/addr forwarded same cycle
        req = 2'b01;
        #1 check("t2_gnt_latency", gnt, 2'b00);
        tick();
        check("t2_gnt", gnt, 2'b01);
        check("t2_req_busy", req_busy, 2'b10);
        req_r_block = 2'b01;
        req_block_addr = {32'h0000_7777, 32'h0000_0010};
        #1;
        check("t2_r_block", spi_r_block, 1'b1);
        check("t2_addr", spi_block_addr, 32'h0000_0010);
        req_r_block = 2'b00;
        spi_err = 1'b1; spi_data_out = 8'h3C;
        #1;
        check("t2_err_pass", err_out, 1'b1);
        check("t2_data_pass", data_out, 8'h3C);
        spi_err = 1'b0;

        // T5: non-owner strobe/data ignored, owner busy reflected
        req = 2'b11;
        req_w_byte = 2'b10;
        req_data_in = {8'hA5, 8'h5A};
        #1;
        check("t5_w_byte_blocked", spi_w_byte, 1'b0);
        check("t5_data_owner", spi_data_in, 8'h5A);
        check("t5_busy_nonowner", req_busy[1], 1'b1);
        req_w_byte = 2'b00;
        spi_busy = 1'b1;
        #1 check("t5_busy_owner", req_busy, 2'b11);
        spi_busy = 1'b0;

        // T3: strict alternation with both requesting; strobe on the drop cycle is ignored
        req = 2'b10;
        req_r_byte = 2'b01;
        #1 check("t3_drop_strobe", spi_r_byte, 1'b0);
        tick();
        req_r_byte = 2'b00;
        check("t3_idle_gap", gnt, 2'b00);
        tick();
        check("t3_gnt1", gnt, 2'b10);
        req = 2'b01;
        tick();
        check("t3_idle_gap2", gnt, 2'b00);
        req = 2'b11;
        tick();
        check("t3_gnt0", gnt, 2'b01);

        // T4: owner 0 drops while host busy for 20 cycles, requester 1 waits for drain plus one idle cycle
        spi_busy = 1'b1;
        req = 2'b10;
        tick();
        check("t4_drain_gnt", gnt, 2'b00);
        repeat (19) tick();
        check("t4_drain_hold", gnt, 2'b00);
        check("t4_drain_busy", req_busy, 2'b11);
        spi_busy = 1'b0;
        tick();
        check("t4_idle_cycle", gnt, 2'b00);
        tick();
        check("t4_gnt1", gnt, 2'b10);

        // T6: reinit ignored from non-owner or while busy, then owner reinit keeps the grant
        req_reinit = 2'b01;
        tick();
        req_reinit = 2'b00;
        check("t6_nonowner_reinit", spi_rst, 1'b0);
        spi_busy = 1'b1;
        req_reinit = 2'b10;
        tick();
        req_reinit = 2'b00;
        check("t6_busy_reinit", spi_rst, 1'b0);
        spi_busy = 1'b0;
        req_reinit = 2'b10;
        tick();
        req_reinit = 2'b00;
        check("t6_reinit_rst", spi_rst, 1'b1);
        check("t6_reinit_gnt", gnt, 2'b10);
        check("t6_reinit_busy", req_busy, 2'b11);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t6_spi_rst_c%0d", i), spi_rst, (i < 4) ? 1'b1 : 1'b0);
        end
        check("t6_gnt_held", gnt, 2'b10);
        tick();
        check("t6_regranted_busy", req_busy, 2'b01);
        check("t6_init_sticky", init_done, 1'b1);
        req_r_block = 2'b10;
        req_block_addr = {32'h0000_2000, 32'h0000_0010};
        #1;
        check("t6_r_block", spi_r_block, 1'b1);
        check("t6_addr", spi_block_addr, 32'h0000_2000);

        // Async reset in the middle of a read session
        spi_busy = 1'b1;
        #1 rst = 1'b1;
        #1 check_reset_vals("t6_async");
        req_r_block = 2'b00;
        tick();
        rst = 1'b0;
        spi_busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t6_rerun_rst_c%0d", i), spi_rst, (i < 4) ? 1'b1 : 1'b0);
        end
        check("t6_rerun_gnt", gnt, 2'b00);
        tick();
        check("t6_rerun_init", init_done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
